// File: rtl/not_gate_sync_if.sv
// Purpose: bundle of the inverter data path and activity-counter signals
//          shared between not_gate_sync and whatever drives/observes it.
// Signals:
//   din      [WIDTH]  data into the inverter
//   cnt_clr           synchronous clear of both activity counters
//   dout     [WIDTH]  bitwise complement of din (comb or registered)
//   rise_cnt [CNT_W]  saturating count of cycles with any din bit rising
//   fall_cnt [CNT_W]  saturating count of cycles with any din bit falling
// Modports:
//   master - drives din/cnt_clr, observes dout and counters
//   slave  - the inverter block itself
interface not_gate_sync_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
);

  logic [WIDTH-1:0] din;
  logic             cnt_clr;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] fall_cnt;

  modport master (
    output din,
    output cnt_clr,
    input  dout,
    input  rise_cnt,
    input  fall_cnt
  );

  modport slave (
    input  din,
    input  cnt_clr,
    output dout,
    output rise_cnt,
    output fall_cnt
  );

endinterface : not_gate_sync_if

// File: rtl/not_gate_sync.sv
// Purpose: parameterizable bitwise inverter with an optional output register
//          and two saturating counters recording input edge activity.
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - synchronous, active-high reset
//   bus  - not_gate_sync_if.slave: din, cnt_clr in; dout, rise_cnt, fall_cnt out
// Parameters:
//   WIDTH      - data width (>= 1)
//   OUTPUT_REG - 0: dout is combinational, 1: dout registered on clk
//   CNT_W      - width of each activity counter (>= 2)
module not_gate_sync #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned OUTPUT_REG = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  not_gate_sync_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Previous-cycle sample of din, used for edge detection.
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] din_d;

  logic             rise_c;
  logic             fall_c;

  logic [CNT_W-1:0] rise_cnt_q;
  logic [CNT_W-1:0] rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q;
  logic [CNT_W-1:0] fall_cnt_d;

  // Edge detection: any bit rising / any bit falling this cycle.
  always_comb begin
    din_d  = bus.din;
    rise_c = |(bus.din & ~din_q);
    fall_c = |(~bus.din & din_q);
  end

  // Counter next-state: clear beats increment, and increments stop at max.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    fall_cnt_d = fall_cnt_q;
    if (bus.cnt_clr) begin
      rise_cnt_d = '0;
      fall_cnt_d = '0;
    end else begin
      if (rise_c && (rise_cnt_q != CNT_MAX)) begin
        rise_cnt_d = rise_cnt_q + CNT_ONE;
      end
      if (fall_c && (fall_cnt_q != CNT_MAX)) begin
        fall_cnt_d = fall_cnt_q + CNT_ONE;
      end
    end
  end

  // Edge-tracking and counter state; din_q keeps sampling during a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q      <= '0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
    end else begin
      din_q      <= din_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign bus.rise_cnt = rise_cnt_q;
  assign bus.fall_cnt = fall_cnt_q;

  // Output path: plain ~din propagates X/Z from din as X on dout.
  generate
    if (OUTPUT_REG != 0) begin : g_reg_out
      logic [WIDTH-1:0] dout_q;
      logic [WIDTH-1:0] dout_d;

      always_comb begin
        dout_d = ~bus.din;
      end

      // Reset value is the complement of the reset-state input (all zeros).
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '1;
        end else begin
          dout_q <= dout_d;
        end
      end

      assign bus.dout = dout_q;
    end else begin : g_comb_out
      assign bus.dout = ~bus.din;
    end
  endgenerate

endmodule : not_gate_sync

// File: tb/tb_not_gate_sync.sv
// Directed bench for not_gate_sync: four instances cover combinational,
// registered, narrow-counter and multi-bit configurations.
module tb_not_gate_sync;

  logic clk;
  logic rst0, rst1, rst2, rst3;
  int   n_total;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  not_gate_sync_if #(.WIDTH(1), .CNT_W(16)) if0 ();
  not_gate_sync_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  not_gate_sync_if #(.WIDTH(1), .CNT_W(2))  if2 ();
  not_gate_sync_if #(.WIDTH(4), .CNT_W(16)) if3 ();

  not_gate_sync #(.WIDTH(1), .OUTPUT_REG(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst0), .bus(if0.slave));
  not_gate_sync #(.WIDTH(1), .OUTPUT_REG(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst1), .bus(if1.slave));
  not_gate_sync #(.WIDTH(1), .OUTPUT_REG(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst2), .bus(if2.slave));
  not_gate_sync #(.WIDTH(4), .OUTPUT_REG(1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst3), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Step past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] comb_vec;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    if0.din = '0; if0.cnt_clr = 1'b0;
    if1.din = '0; if1.cnt_clr = 1'b0;
    if2.din = '0; if2.cnt_clr = 1'b0;
    if3.din = '0; if3.cnt_clr = 1'b0;

    // Combinational toggle, also while held in reset.
    comb_vec = 7'b1010101;
    for (int i = 0; i < 7; i++) begin
      if0.din = (i % 2 == 1) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("comb_dout_%0d", i), 32'(if0.dout), 32'(comb_vec[6-i]));
      #9;
    end
    if0.din = 1'b0;
    tick();
    tick();

    // Reset state of all instances.
    chk("rst_u0_rise", 32'(if0.rise_cnt), 32'd0);
    chk("rst_u0_fall", 32'(if0.fall_cnt), 32'd0);
    chk("rst_u1_dout", 32'(if1.dout), 32'd1);
    chk("rst_u1_rise", 32'(if1.rise_cnt), 32'd0);
    chk("rst_u3_dout", 32'(if3.dout), 32'hF);

    // Counting: toggle every cycle for six cycles starting 0->1.
    rst0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if0.din = ~if0.din;
      tick();
      if (i == 0) begin
        chk("cnt_first_rise", 32'(if0.rise_cnt), 32'd1);
        chk("cnt_first_fall", 32'(if0.fall_cnt), 32'd0);
      end
    end
    chk("cnt_rise_6", 32'(if0.rise_cnt), 32'd3);
    chk("cnt_fall_6", 32'(if0.fall_cnt), 32'd3);

    // Registered mode: din 0,1,0 on successive edges.
    rst1 = 1'b0;
    if1.din = 1'b0; tick();
    chk("reg_dout_0", 32'(if1.dout), 32'd1);
    if1.din = 1'b1; #1;
    chk("reg_latency", 32'(if1.dout), 32'd1);
    tick();
    chk("reg_dout_1", 32'(if1.dout), 32'd0);
    if1.din = 1'b0; tick();
    chk("reg_dout_2", 32'(if1.dout), 32'd1);
    // Counters now 1/1; seven more toggles reach 5/4 ending with din=1.
    for (int i = 0; i < 7; i++) begin
      if1.din = ~if1.din;
      tick();
    end
    chk("pre_rst_rise", 32'(if1.rise_cnt), 32'd5);
    chk("pre_rst_fall", 32'(if1.fall_cnt), 32'd4);
    chk("pre_rst_dout", 32'(if1.dout), 32'd0);

    // Mid-operation reset with din glitching before the edge.
    rst1 = 1'b1;
    if1.din = 1'b0;
    #1;
    chk("rst_hold_rise", 32'(if1.rise_cnt), 32'd5);
    #1;
    if1.din = 1'b1;
    tick();
    chk("mid_rst_rise", 32'(if1.rise_cnt), 32'd0);
    chk("mid_rst_fall", 32'(if1.fall_cnt), 32'd0);
    chk("mid_rst_dout", 32'(if1.dout), 32'd1);
    chk("mid_rst_din_q", 32'(u1.din_q), 32'd0);
    rst1 = 1'b0;
    tick();
    chk("post_rst_rise", 32'(if1.rise_cnt), 32'd1);
    chk("post_rst_fall", 32'(if1.fall_cnt), 32'd0);
    chk("post_rst_dout", 32'(if1.dout), 32'd0);

    // Saturation with CNT_W=2: five rises and five falls.
    rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if2.din = 1'b1; tick();
      if2.din = 1'b0; tick();
      if (i == 1) chk("sat_rise_2", 32'(if2.rise_cnt), 32'd2);
    end
    chk("sat_rise", 32'(if2.rise_cnt), 32'd3);
    chk("sat_fall", 32'(if2.fall_cnt), 32'd3);
    tick();
    chk("sat_hold", 32'(if2.rise_cnt), 32'd3);

    // Clear coinciding with a rise: cleared, rise not counted.
    if2.din = 1'b1; if2.cnt_clr = 1'b1; tick();
    chk("clr_rise", 32'(if2.rise_cnt), 32'd0);
    chk("clr_fall", 32'(if2.fall_cnt), 32'd0);
    if2.cnt_clr = 1'b0;
    if2.din = 1'b0; tick();
    chk("after_clr_fall", 32'(if2.fall_cnt), 32'd1);
    if2.din = 1'b1; tick();
    chk("after_clr_rise", 32'(if2.rise_cnt), 32'd1);

    // Multi-bit: simultaneous rise and fall on different bits.
    rst3 = 1'b0;
    if3.din = 4'b0011; tick();
    chk("mb_rise_1", 32'(if3.rise_cnt), 32'd1);
    chk("mb_fall_0", 32'(if3.fall_cnt), 32'd0);
    chk("mb_dout_1", 32'(if3.dout), 32'hC);
    if3.din = 4'b1100; tick();
    chk("mb_rise_2", 32'(if3.rise_cnt), 32'd2);
    chk("mb_fall_1", 32'(if3.fall_cnt), 32'd1);
    chk("mb_dout_2", 32'(if3.dout), 32'h3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_not_gate_sync

// File: doc/not_gate_sync.md
# not_gate_sync

Parameterizable bitwise inverter with an optional registered output and saturating input-edge activity counters. It is a leaf utility block that sits directly on a signal path: `dout` is the logical complement of `din`. The counters give verification and debug a cycle-accurate record of input toggling. The module is named `not_gate_sync`; the inversion function is that of the `not_gate` primitive.

## Interface
Parameters:
- `WIDTH`, default 1: data width in bits (≥1).
- `OUTPUT_REG`, default 0:
  - 0 → `dout` is combinational.
  - 1 → `dout` is registered on `clk`.
- `CNT_W`, default 16: width of each activity counter (≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: rising-edge clock for all state.
- `rst` input 1: synchronous, active-high reset.
- `din` input WIDTH: data input.
- `cnt_clr` input 1: synchronous clear of both counters.
- `dout` output WIDTH: bitwise complement of `din`.
- `rise_cnt` output CNT_W: count of cycles with at least one `din` bit rising.
- `fall_cnt` output CNT_W: count of cycles with at least one `din` bit falling.

## Operation
- Inversion:
  - Bit i of `dout` = NOT bit i of `din`, for every i.
  - No X masking.
  - An X/Z on `din` propagates as X on `dout`.
- `OUTPUT_REG=0`:
  - `dout` is purely combinational.
  - `dout` is unaffected by `clk`/`rst`.
- `OUTPUT_REG=1`:
  - On each rising `clk`, `dout` ← ~`din`.
  - On `rst`, `dout` ← all ones (the complement of the reset-state input 0).
- Edge tracking:
  - Internal register `din_q` (WIDTH) samples `din` every clock.
  - `din_q` resets to 0.
  - rise = |(`din` & ~`din_q`).
  - fall = |(~`din` & `din_q`).
- Counters:
  - `rise_cnt` increments by 1 on a clock where rise=1.
  - `fall_cnt` increments by 1 on a clock where fall=1.
  - Both saturate at 2^CNT_W−1; there is no wrap.
- Multi-bit case: rise and fall can both be 1 in the same cycle (different bits). Both counters then increment in that cycle.
- Priority per clock: `rst` > `cnt_clr` > increment.
  - `cnt_clr` zeroes both counters.
  - An edge coinciding with `cnt_clr` is not counted.
  - `din_q` still samples during `cnt_clr`.
- Reset:
  - `din_q` = 0.
  - `rise_cnt` = 0.
  - `fall_cnt` = 0.
  - Registered `dout` = all ones.
  - If `din`=1 on the first clock after reset release, it counts as a rise.

## Timing
- Combinational `dout` (`OUTPUT_REG=0`):
  - Zero-cycle latency; follows `din` within the same delta/propagation delay.
  - Valid during reset.
- Registered `dout` (`OUTPUT_REG=1`):
  - 1-cycle latency.
  - `din` sampled at edge N appears on `dout` after edge N.
- Counters:
  - A `din` transition occurring between edges N−1 and N is detected at edge N.
  - The counter value is updated after edge N, i.e. 1-cycle latency from the sampling edge.
- Inputs changing more than once between edges are seen only at the sampled value; no glitch counting.
- Reset asserted mid-operation takes effect at the next rising edge only.
- Counters and registered `dout` hold their values until that edge.

## Test plan
- Combinational toggle (`WIDTH=1`, `OUTPUT_REG=0`):
  - Stimulus: `din` = 0,1,0,1,0,1,0, each held 10 ns.
  - Required: `dout` = 1,0,1,0,1,0,1 immediately after each change.
- Counting (10 ns `clk`, `rst` for 2 cycles, then toggle `din` every cycle for 6 cycles starting 0→1):
  - Required after the last edge: `rise_cnt`=3, `fall_cnt`=3.
- Registered mode (`OUTPUT_REG=1`):
  - During reset, `dout`=1.
  - Drive `din`=0,1,0 on successive edges.
  - Required: `dout` shows 1,0,1, each one cycle after sampling.
- Saturation and clear (`CNT_W=2`):
  - Generate 5 rises.
  - Required: `rise_cnt`=3, holding.
  - Assert `cnt_clr` on the same edge as a rise.
  - Required: both counters=0, and the next rise gives `rise_cnt`=1.
- Multi-bit simultaneous (`WIDTH=4`):
  - `din` 4'b0011 → 4'b1100 in one cycle.
  - Required: `rise_cnt` +1 and `fall_cnt` +1 on that edge; `dout`=4'b0011.
- Mid-operation reset:
  - With counters at 5/4, assert `rst` for one edge while `din` toggles.
  - Required: counters=0, registered `dout`=all ones, `din_q`=0 after that edge.
